// File: rtl/multicycle_control_v2.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing with memory latency and stall.
// Optional interrupt entry state enabled by defining CTRL_IRQ_EN.
module multicycle_control_v2 #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned TYPE_W  = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TYPE_W-1:0] inst_type,
  input  logic              inst_update_flags,
  input  logic              inst_update_regfile,
  input  logic              branch_taken,
  input  logic              stall,
`ifdef CTRL_IRQ_EN
  input  logic              irq,
  output logic              irq_ack,
`endif
  output logic              ctrl_pc_en,
  output logic [1:0]        ctrl_pc_sel,
  output logic              ctrl_ir_en,
  output logic              ctrl_ir_decode,
  output logic              ctrl_fr_en,
  output logic              ctrl_regfile_we,
  output logic [1:0]        ctrl_wb_sel,
  output logic              ctrl_mem_addr,
  output logic              ctrl_mem_we,
  output logic              halted
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StReg      = 4'd2,
    StLoadAddr = 4'd3,
    StLoadWb   = 4'd4,
    StStore    = 4'd5,
    StBranch   = 4'd6,
    StJump     = 4'd7,
    StNop      = 4'd8,
    StHalt     = 4'd9,
    StIrq      = 4'd10
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           done_state;

  // Every instruction completion funnels through here so the interrupt hook sits in one place.
`ifdef CTRL_IRQ_EN
  assign done_state = irq ? StIrq : StFetch;
`else
  assign done_state = StFetch;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ctrl_pc_en      = 1'b0;
    ctrl_pc_sel     = 2'd0;
    ctrl_ir_en      = 1'b0;
    ctrl_ir_decode  = 1'b0;
    ctrl_fr_en      = 1'b0;
    ctrl_regfile_we = 1'b0;
    ctrl_wb_sel     = 2'd0;
    ctrl_mem_addr   = 1'b0;
    ctrl_mem_we     = 1'b0;
    halted          = 1'b0;
`ifdef CTRL_IRQ_EN
    irq_ack         = 1'b0;
`endif
    case (state_q)
      StFetch: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDecode;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDecode: begin
        ctrl_ir_en = 1'b1;
        case (inst_type)
          TYPE_W'(0): state_d = StReg;
          TYPE_W'(1): state_d = StLoadAddr;
          TYPE_W'(2): state_d = StStore;
          TYPE_W'(3): state_d = StBranch;
          TYPE_W'(4): state_d = StJump;
          TYPE_W'(5): state_d = StHalt;
          default:    state_d = StNop;
        endcase
      end
      StReg: begin
        ctrl_pc_en      = 1'b1;
        ctrl_fr_en      = inst_update_flags;
        ctrl_regfile_we = inst_update_regfile;
        state_d         = done_state;
      end
      StLoadAddr: begin
        ctrl_mem_addr = 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StLoadWb;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLoadWb: begin
        ctrl_pc_en      = 1'b1;
        ctrl_ir_decode  = 1'b1;
        ctrl_fr_en      = inst_update_flags;
        ctrl_regfile_we = inst_update_regfile;
        ctrl_wb_sel     = 2'd1;
        state_d         = done_state;
      end
      StStore: begin
        ctrl_pc_en    = 1'b1;
        ctrl_mem_addr = 1'b1;
        ctrl_mem_we   = 1'b1;
        state_d       = done_state;
      end
      StBranch: begin
        ctrl_pc_en  = 1'b1;
        ctrl_pc_sel = branch_taken ? 2'd1 : 2'd0;
        state_d     = done_state;
      end
      StJump: begin
        ctrl_pc_en      = 1'b1;
        ctrl_pc_sel     = 2'd2;
        ctrl_regfile_we = inst_update_regfile;
        ctrl_wb_sel     = 2'd2;
        state_d         = done_state;
      end
      StNop: begin
        ctrl_pc_en = 1'b1;
        state_d    = done_state;
      end
      StHalt: begin
        halted = 1'b1;
      end
`ifdef CTRL_IRQ_EN
      StIrq: begin
        ctrl_pc_en      = 1'b1;
        ctrl_pc_sel     = 2'd3;
        ctrl_regfile_we = 1'b1;
        ctrl_wb_sel     = 2'd2;
        irq_ack         = 1'b1;
        state_d         = StFetch;
      end
`endif
      default: begin
        state_d = StFetch;
        cnt_d   = '0;
      end
    endcase

    // Stall freezes progress; selects stay valid so the datapath sees stable muxes.
    if (stall) begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      ctrl_pc_en      = 1'b0;
      ctrl_ir_en      = 1'b0;
      ctrl_fr_en      = 1'b0;
      ctrl_regfile_we = 1'b0;
      ctrl_mem_we     = 1'b0;
`ifdef CTRL_IRQ_EN
      irq_ack         = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Directed table-driven bench for multicycle_control_v2 at MEM_LAT=1 and MEM_LAT=3.
module tb_multicycle_control_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] inst_type = 3'd0;
  logic       uf = 1'b0, ur = 1'b0, bt = 1'b0, stall = 1'b0;

  logic       pc_en_a, ir_en_a, ir_dec_a, fr_en_a, rf_we_a, ma_a, mw_a, halted_a;
  logic [1:0] pc_sel_a, wb_sel_a;
  logic       pc_en_b, ir_en_b, ir_dec_b, fr_en_b, rf_we_b, ma_b, mw_b, halted_b;
  logic [1:0] pc_sel_b, wb_sel_b;
  logic [11:0] out_a, out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_v2 #(.MEM_LAT(1), .TYPE_W(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .inst_type(inst_type), .inst_update_flags(uf),
    .inst_update_regfile(ur), .branch_taken(bt), .stall(stall),
    .ctrl_pc_en(pc_en_a), .ctrl_pc_sel(pc_sel_a), .ctrl_ir_en(ir_en_a),
    .ctrl_ir_decode(ir_dec_a), .ctrl_fr_en(fr_en_a), .ctrl_regfile_we(rf_we_a),
    .ctrl_wb_sel(wb_sel_a), .ctrl_mem_addr(ma_a), .ctrl_mem_we(mw_a), .halted(halted_a)
  );

  multicycle_control_v2 #(.MEM_LAT(3), .TYPE_W(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .inst_type(inst_type), .inst_update_flags(uf),
    .inst_update_regfile(ur), .branch_taken(bt), .stall(stall),
    .ctrl_pc_en(pc_en_b), .ctrl_pc_sel(pc_sel_b), .ctrl_ir_en(ir_en_b),
    .ctrl_ir_decode(ir_dec_b), .ctrl_fr_en(fr_en_b), .ctrl_regfile_we(rf_we_b),
    .ctrl_wb_sel(wb_sel_b), .ctrl_mem_addr(ma_b), .ctrl_mem_we(mw_b), .halted(halted_b)
  );

  assign out_a = {pc_en_a, pc_sel_a, ir_en_a, ir_dec_a, fr_en_a, rf_we_a, wb_sel_a,
                  ma_a, mw_a, halted_a};
  assign out_b = {pc_en_b, pc_sel_b, ir_en_b, ir_dec_b, fr_en_b, rf_we_b, wb_sel_b,
                  ma_b, mw_b, halted_b};

  typedef struct {
    bit          d3;
    bit          rs;
    bit          chk;
    logic [2:0]  typ;
    logic        uf;
    logic        ur;
    logic        bt;
    logic        st;
    logic [11:0] exp;
  } vec_t;

  vec_t v1[$];
  vec_t v3[$];

  // Packs outputs as {pc_en, pc_sel, ir_en, ir_dec, fr_en, rf_we, wb_sel, mem_addr, mem_we, halted}
  function automatic logic [11:0] o(logic pe, logic [1:0] ps, logic ie, logic id, logic fe,
                                    logic rw, logic [1:0] ws, logic ma, logic mw, logic h);
    return {pe, ps, ie, id, fe, rw, ws, ma, mw, h};
  endfunction

  function automatic vec_t mk(bit d3, bit rs, bit chk, logic [2:0] typ, logic f, logic r,
                              logic b, logic s, logic [11:0] exp);
    vec_t v;
    v.d3 = d3; v.rs = rs; v.chk = chk; v.typ = typ;
    v.uf = f; v.ur = r; v.bt = b; v.st = s; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v, string name);
    inst_type = v.typ;
    uf        = v.uf;
    ur        = v.ur;
    bt        = v.bt;
    stall     = v.st;
    rst       = v.rs;
    #1;
    if (v.chk) check(name, v.d3 ? out_b : out_a, v.exp);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [11:0] z, ir, hlt, pc1, sts;

  initial begin
    z   = '0;
    ir  = o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    hlt = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    pc1 = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sts = o(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // MEM_LAT=1 instance: one FETCH cycle per instruction
    v1.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, ir));
    v1.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, o(1, 0, 0, 0, 1, 1, 0, 0, 0, 0)));
    v1.push_back(mk(0, 0, 1, 3, 0, 0, 1, 0, z));
    v1.push_back(mk(0, 0, 1, 3, 0, 0, 1, 0, ir));
    v1.push_back(mk(0, 0, 1, 3, 0, 0, 1, 1, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    v1.push_back(mk(0, 0, 1, 3, 0, 0, 1, 0, o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    v1.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, ir));
    v1.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, pc1));
    v1.push_back(mk(0, 0, 1, 4, 0, 1, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 4, 0, 1, 0, 0, ir));
    v1.push_back(mk(0, 0, 1, 4, 0, 1, 0, 0, o(1, 2, 0, 0, 0, 1, 2, 0, 0, 0)));
    v1.push_back(mk(0, 0, 1, 7, 1, 1, 1, 0, z));
    v1.push_back(mk(0, 0, 1, 7, 1, 1, 1, 0, ir));
    v1.push_back(mk(0, 0, 1, 7, 1, 1, 1, 0, pc1));
    v1.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, ir));
    v1.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, pc1));
    v1.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, ir));
    for (int i = 0; i < 4; i++) v1.push_back(mk(0, 0, 1, 2, 0, 0, 0, 1, sts));
    v1.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 1, 1, 0)));
    v1.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, ir));
    v1.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, sts));
    v1.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, o(0, 0, 0, 1, 0, 0, 1, 0, 0, 0)));
    v1.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, o(1, 0, 0, 1, 1, 1, 1, 0, 0, 0)));
    v1.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0, z));
    v1.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0, ir));
    v1.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0, hlt));

    // MEM_LAT=3 instance: full load, then counter hold under stall and reset mid-load
    v3.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, z));
    for (int i = 0; i < 3; i++) v3.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, ir));
    for (int i = 0; i < 3; i++) v3.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, sts));
    v3.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, o(1, 0, 0, 1, 1, 0, 1, 0, 0, 0)));
    v3.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, z));
    v3.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, z));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, z));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, z));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, ir));
    v3.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, sts));
    v3.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, sts));
    v3.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, z));
    v3.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, ir));

    foreach (v1[i]) run_vec(v1[i], $sformatf("lat1[%0d]", i));

    // HALT must ignore every input except reset
    for (int i = 0; i < 20; i++) begin
      inst_type = 3'($urandom_range(0, 7));
      uf        = 1'($urandom_range(0, 1));
      ur        = 1'($urandom_range(0, 1));
      bt        = 1'($urandom_range(0, 1));
      stall     = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halt_hold[%0d]", i), out_a, hlt);
      @(posedge clk);
      #1;
    end
    run_vec(mk(0, 1, 1, 0, 0, 0, 0, 0, hlt), "halt_rst_edge");
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, z), "halt_rst_fetch");
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, ir), "halt_rst_decode");

    foreach (v3[i]) run_vec(v3[i], $sformatf("lat3[%0d]", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
